// File: rtl/potential_accumulator.sv
// Integrate-and-fire potential accumulator: sums a weight stream onto the decayed
// potential, compares against threshold and fires with an optional refractory period.
module potential_accumulator #(
    parameter logic [31:0] V_RESET    = 32'h00000000,
    parameter int unsigned REFRACTORY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        empty,
    input  logic [31:0] decayed_potential,
    input  logic [31:0] threshold,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic [31:0] weight,
    input  logic        weight_last,
    output logic [31:0] new_potential,
    output logic        spike,
    output logic        done,
    output logic        busy,
    output logic        exception
);

    localparam int unsigned FW = 32;
    localparam int unsigned CW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t          state, state_d;
    logic [FW-1:0]   acc, acc_d, thr, thr_d, np_d;
    logic [CW-1:0]   ref_cnt, ref_d;
    logic            spike_d, done_d, exc_d, ready_d, busy_d, fire_nan;
    logic [FW:0]     add_res;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Signed-magnitude >= with +0 == -0; callers exclude NaN.
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b1;
        if (a[31] != b[31])                      return !a[31];
        if (!a[31])                              return a[30:0] >= b[30:0];
        return a[30:0] <= b[30:0];
    endfunction

    // Single-precision add, round-to-nearest-even; bit 32 flags an Inf/NaN result.
    function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        sl, ss, rnd, sticky;
        logic [7:0]  el, es, d;
        logic [23:0] ml, ms;
        logic [26:0] xl, xs, mask, norm;
        logic [27:0] sum;
        logic [9:0]  e;
        logic [4:0]  lz, sh;
        logic [30:0] mag;
        logic [31:0] res;
        sl = a[31]; ss = b[31]; el = a[30:23]; es = b[30:23];
        ml = '0; ms = '0; d = '0; xl = '0; xs = '0; mask = '0; norm = '0;
        sum = '0; e = '0; lz = '0; sh = '0; mag = '0; rnd = 1'b0; sticky = 1'b0;
        res = '0;
        if (is_nan(a) || is_nan(b) ||
            (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])) begin
            res = 32'h7FC00000;
        end else if (a[30:23] == 8'hFF) begin
            res = a;
        end else if (b[30:23] == 8'hFF) begin
            res = b;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                sl = a[31]; el = a[30:23]; ml = {a[30:23] != 8'd0, a[22:0]};
                ss = b[31]; es = b[30:23]; ms = {b[30:23] != 8'd0, b[22:0]};
            end else begin
                sl = b[31]; el = b[30:23]; ml = {b[30:23] != 8'd0, b[22:0]};
                ss = a[31]; es = a[30:23]; ms = {a[30:23] != 8'd0, a[22:0]};
            end
            if (el == 8'd0) el = 8'd1;
            if (es == 8'd0) es = 8'd1;
            d  = el - es;
            xl = {ml, 3'b000};
            if (d >= 8'd27) begin
                xs     = '0;
                sticky = |ms;
            end else begin
                xs     = {ms, 3'b000} >> d;
                mask   = (27'd1 << d) - 27'd1;
                sticky = |({ms, 3'b000} & mask);
            end
            xs[0] = xs[0] | sticky;
            sum = (sl == ss) ? ({1'b0, xl} + {1'b0, xs}) : ({1'b0, xl} - {1'b0, xs});
            e   = {2'b00, el};
            if (sum == 28'd0) begin
                res = {sl & ss, 31'd0};
            end else begin
                if (sum[27]) begin
                    norm = sum[27:1] | {26'd0, sum[0]};
                    e    = e + 10'd1;
                end else begin
                    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
                    // Left shift stops at the minimum exponent; leftovers are subnormal.
                    sh   = (10'(lz) < e) ? lz : 5'(e - 10'd1);
                    norm = sum[26:0] << sh;
                    e    = e - 10'(sh);
                    if (!norm[26]) e = '0;
                end
                rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
                if (e >= 10'd255) begin
                    res = {sl, 8'hFF, 23'd0};
                end else begin
                    mag = {e[7:0], norm[25:3]} + 31'(rnd);
                    res = {sl, mag};
                end
            end
        end
        return {res[30:23] == 8'hFF, res};
    endfunction

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d  = state;
        acc_d    = acc;
        thr_d    = thr;
        ref_d    = ref_cnt;
        np_d     = new_potential;
        spike_d  = 1'b0;
        done_d   = 1'b0;
        exc_d    = exception;
        add_res  = fp_add(acc, weight);
        fire_nan = is_nan(acc) | is_nan(thr);
        case (state)
            IDLE: begin
                if (start) begin
                    acc_d   = decayed_potential;
                    thr_d   = threshold;
                    state_d = empty ? FIRE : ACCUM;
                end
            end
            ACCUM: begin
                if (weight_valid) begin
                    acc_d = add_res[FW-1:0];
                    exc_d = exception | add_res[FW];
                    if (weight_last) state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (fire_nan) exc_d = 1'b1;
                if (ref_cnt != '0) begin
                    np_d  = V_RESET;
                    ref_d = ref_cnt - CW'(1);
                end else if (!fire_nan && fp_ge(acc, thr)) begin
                    spike_d = 1'b1;
                    np_d    = V_RESET;
                    ref_d   = CW'(REFRACTORY);
                end else begin
                    np_d = acc;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == ACCUM);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= IDLE;
            acc           <= '0;
            thr           <= '0;
            ref_cnt       <= '0;
            new_potential <= '0;
            spike         <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            weight_ready  <= 1'b0;
            exception     <= 1'b0;
        end else begin
            state         <= state_d;
            acc           <= acc_d;
            thr           <= thr_d;
            ref_cnt       <= ref_d;
            new_potential <= np_d;
            spike         <= spike_d;
            done          <= done_d;
            busy          <= busy_d;
            weight_ready  <= ready_d;
            exception     <= exc_d;
        end
    end

endmodule

// File: tb/tb_potential_accumulator.sv
// Randomized bench for potential_accumulator against a real-arithmetic reference model.
module tb_potential_accumulator;

    localparam logic [31:0] V_RST = 32'h00000000;
    localparam int          REFR  = 2;

    logic        CLK, RESET, start, empty, weight_valid, weight_ready, weight_last;
    logic [31:0] decayed_potential, threshold, weight, new_potential;
    logic        spike, done, busy, exception;

    potential_accumulator #(.V_RESET(V_RST), .REFRACTORY(REFR)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .empty(empty),
        .decayed_potential(decayed_potential), .threshold(threshold),
        .weight_valid(weight_valid), .weight_ready(weight_ready),
        .weight(weight), .weight_last(weight_last),
        .new_potential(new_potential), .spike(spike), .done(done),
        .busy(busy), .exception(exception)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int          m_ref = 0;
    bit          m_exc = 1'b0;
    logic [31:0] m_np  = 32'd0;
    logic [31:0] wq [8];
    logic        sp;
    logic [31:0] np;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit f_nan(input logic [31:0] f);
        return f[30:23] == 8'hFF && f[22:0] != 23'd0;
    endfunction

    function automatic bit f_inf(input logic [31:0] f);
        return f[30:23] == 8'hFF && f[22:0] == 23'd0;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, 52'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round a double to single precision (normal range, nearest-even).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [30:0] v;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        v = {8'(e), d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) v = v + 31'd1;
        return {d[63], v};
    endfunction

    function automatic logic [32:0] m_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (f_nan(a) || f_nan(b) || (f_inf(a) && f_inf(b) && a[31] != b[31])) r = 32'h7FC00000;
        else if (f_inf(a)) r = a;
        else if (f_inf(b)) r = b;
        else r = r2f(f2r(a) + f2r(b));
        return {r[30:23] == 8'hFF, r};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        check("rst_ready", 32'(weight_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spike", 32'(spike), 32'd0);
        check("rst_exc", 32'(exception), 32'd0);
        check("rst_np", new_potential, 32'd0);
        RESET = 1'b1;
        m_ref = 0; m_exc = 1'b0; m_np = 32'd0;
    endtask

    task automatic idle_noise(input int k);
        for (int c = 0; c < k; c++) begin
            weight_valid = 1'b1;
            weight       = rnd_f();
            weight_last  = 1'($urandom_range(0, 1));
            tick();
            check("idle_ready", 32'(weight_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        weight_valid = 1'b0;
    endtask

    // One timestep of n weights from wq; called and returns at 1 time unit after a rising edge.
    task automatic run_step(input logic [31:0] dec, input logic [31:0] th, input int n,
                            input bit gaps, input bit noise,
                            output logic sp_o, output logic [31:0] np_o);
        int          cyc, i, c_last;
        bit          acc_now, rdy_exp, nanf, m_spike;
        logic [31:0] m_acc;
        logic [32:0] ar;
        m_acc = dec;
        for (int k = 0; k < n; k++) begin
            ar    = m_add(m_acc, wq[k]);
            m_acc = ar[31:0];
            if (ar[32]) m_exc = 1'b1;
        end
        start = 1'b1; empty = (n == 0); decayed_potential = dec; threshold = th;
        weight_valid = 1'b0; weight_last = 1'b0;
        tick();
        cyc = 1; i = 0; c_last = 0;
        start = 1'b0; decayed_potential = rnd_f(); threshold = rnd_f();
        while (done !== 1'b1 && cyc < 64) begin
            rdy_exp = (i < n);
            check("ready", 32'(weight_ready), 32'(rdy_exp));
            check("busy", 32'(busy), 32'd1);
            start = noise && ($urandom_range(0, 3) == 0);
            empty = 1'($urandom_range(0, 1));
            if (i < n) begin
                weight_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                weight       = wq[i];
                weight_last  = (i == n - 1);
            end else begin
                weight_valid = noise && ($urandom_range(0, 1) == 1);
                weight       = rnd_f();
                weight_last  = 1'($urandom_range(0, 1));
            end
            acc_now = weight_valid && rdy_exp;
            if (acc_now) c_last = cyc;
            tick();
            cyc++;
            if (acc_now) i++;
        end
        start = 1'b0; weight_valid = 1'b0;
        check("latency", 32'(cyc), 32'(c_last + 2));
        nanf = f_nan(m_acc) || f_nan(th);
        if (nanf) m_exc = 1'b1;
        m_spike = 1'b0;
        if (m_ref > 0) begin
            m_np = V_RST;
            m_ref--;
        end else if (!nanf && f2r(m_acc) >= f2r(th)) begin
            m_spike = 1'b1;
            m_np    = V_RST;
            m_ref   = REFR;
        end else begin
            m_np = m_acc;
        end
        check("done", 32'(done), 32'd1);
        check("spike", 32'(spike), 32'(m_spike));
        check("new_potential", new_potential, m_np);
        check("exception", 32'(exception), 32'(m_exc));
        sp_o = spike;
        np_o = new_potential;
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("spike_pulse", 32'(spike), 32'd0);
        check("np_hold", new_potential, m_np);
        check("idle_busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; start = 1'b0; empty = 1'b0; weight_valid = 1'b0; weight_last = 1'b0;
        decayed_potential = 32'd0; threshold = 32'd0; weight = 32'd0;
        tick();
        do_reset();
        tick();

        for (int k = 0; k < 3; k++) wq[k] = 32'h3F800000;
        run_step(32'h41DED852, 32'h41F00000, 3, 1'b0, 1'b0, sp, np);
        check("r028_spike", 32'(sp), 32'd1);
        check("r028_np", np, 32'h00000000);

        wq[0] = 32'h42C80000;
        for (int t = 0; t < 2; t++) begin
            run_step(32'h41DED852, 32'h41F00000, 1, 1'b0, 1'b0, sp, np);
            check("r031_refr_spike", 32'(sp), 32'd0);
            check("r031_refr_np", np, 32'h00000000);
        end
        run_step(32'h41DED852, 32'h41F00000, 1, 1'b0, 1'b0, sp, np);
        check("r031_third_spike", 32'(sp), 32'd1);

        // Reset mid-ACCUM after two accepted weights, while still refractory.
        start = 1'b1; empty = 1'b0; decayed_potential = 32'h41DED852; threshold = 32'h41F00000;
        tick();
        start = 1'b0; weight_valid = 1'b1; weight = 32'h3F800000; weight_last = 1'b0;
        tick();
        tick();
        check("r032_busy_before", 32'(busy), 32'd1);
        do_reset();
        weight_last = 1'b1;
        idle_noise(4);
        for (int k = 0; k < 3; k++) wq[k] = 32'h3F800000;
        run_step(32'h41DED852, 32'h41F00000, 3, 1'b0, 1'b0, sp, np);
        check("r027_fresh_spike", 32'(sp), 32'd1);

        do_reset();
        wq[0] = 32'h3F800000;
        run_step(32'h41DED852, 32'h41F00000, 1, 1'b0, 1'b0, sp, np);
        check("r029_spike", 32'(sp), 32'd0);
        check("r029_np", np, 32'h41E6D852);
        run_step(32'h41DED852, 32'h41F00000, 0, 1'b0, 1'b0, sp, np);
        check("r030_spike", 32'(sp), 32'd0);
        check("r030_np", np, 32'h41DED852);

        wq[0] = rnd_f(); wq[1] = rnd_f();
        run_step(32'h41DED852, 32'h7FC00000, 2, 1'b1, 1'b1, sp, np);
        check("r033_spike", 32'(sp), 32'd0);
        check("r033_exc", 32'(exception), 32'd1);
        wq[0] = 32'h3F800000;
        run_step(32'h41DED852, 32'h41F00000, 1, 1'b0, 1'b0, sp, np);
        check("r033_exc_sticky", 32'(exception), 32'd1);
        do_reset();

        wq[0] = 32'h7F7FFFFF;
        run_step(32'h7F7FFFFF, 32'h00000000, 1, 1'b0, 1'b0, sp, np);
        check("ovf_exc", 32'(exception), 32'd1);
        check("ovf_spike", 32'(sp), 32'd1);
        do_reset();

        for (int t = 0; t < 150; t++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) wq[k] = rnd_f();
            run_step(rnd_f(), rnd_f(), n, 1'($urandom_range(0, 1)), 1'b1, sp, np);
            idle_noise($urandom_range(0, 2));
            if (t % 50 == 49) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
